mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles a memory operation may take after issue before timeout_err is raised.
REQ-002 SHALL use one clock; reset is asynchronous and active-low (ports clk, rst).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 req_a / req_b  in  1  operation request, requester A (traversal) / B (execute).
REQ-006 func_a / func_b  in  2  memory function code.
REQ-007 addr1_a, addr2_a / addr1_b, addr2_b  in  `memory_addr_width  operation addresses.
REQ-008 wdata_a / wdata_b  in  `memory_data_width  write data.
REQ-009 lock_a / lock_b  in  1  owner keeps the memory for its next request.
REQ-010 gnt_a / gnt_b  out  1  one-cycle pulse; request fields sampled this cycle.
REQ-011 done_a / done_b  out  1  one-cycle pulse; operation complete, rdata valid.
REQ-012 rdata1, rdata2  out  `memory_data_width  captured read data, held until the next completion.
REQ-013 mem_func, mem_execute, mem_address1, mem_address2, mem_write_data  out  memory_unit command port, same widths.
REQ-014 mem_ready  in  1; mem_read_data1, mem_read_data2  in  `memory_data_width  memory_unit status and data.
REQ-015 owner  out  1  0 = A, 1 = B, the current or last grantee; busy  out  1  high outside IDLE; timeout_err  out  1  sticky.

Function
REQ-016 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ERR.
REQ-017 In IDLE, with mem_ready=1 and at least one req: at the edge, latch the grantee's func, addresses and wdata, pulse its gnt, and go to ISSUE.
REQ-018 Arbitration: a single requester wins; if both request, the requester not last served wins (round-robin); the pointer after reset favours A.
REQ-019 Lock: if the last owner's lock was high at its done and it requests, it wins regardless of the pointer; while locked, the other requester stalls; lock low restores round-robin.
REQ-020 In IDLE with mem_ready=0, no grant is issued.
REQ-021 ISSUE: mem_execute=1 for exactly one cycle, with the latched command on mem_*; go to WAIT_BUSY.
REQ-022 WAIT_BUSY: stay until mem_ready=0, then go to WAIT_DONE.
REQ-023 WAIT_DONE: on mem_ready=1, capture mem_read_data1/2 into rdata1/2, pulse the owner's done, update the round-robin pointer, and go to IDLE.
REQ-024 Minimum latency: gnt at cycle N+1 after req is sampled at N; mem_execute coincides with the cycle after gnt; no back-to-back grant is issued in the done cycle.
REQ-025 mem_address*, mem_func and mem_write_data SHALL hold the latched values outside ISSUE; mem_execute=0 outside ISSUE.
REQ-026 Timer: 8+ bit counter, cleared in ISSUE, incremented in WAIT_BUSY and WAIT_DONE; on reaching TIMEOUT_CYCLES, set timeout_err and go to ERR.
REQ-027 ERR: no grants, no done, mem_execute=0, busy=1; exit only by reset.
REQ-028 A req withdrawn before gnt is ignored; a req held high during the owner's operation is served after the return to IDLE.
REQ-029 A request never issues gnt to both requesters in the same cycle, and each gnt is followed by exactly one done (absent timeout).

Reset
REQ-030 rst low SHALL immediately force IDLE, all gnt, done, mem_execute, busy and timeout_err to 0, rdata and mem_* buses to 0, owner=0, the pointer to favour A, the lock to be released and the timer to 0, including mid-operation.
REQ-031 The first grant SHALL occur no earlier than the first edge after rst rises.

Verification
REQ-032 Single A read at addr1=1: req_a held -> gnt_a the next cycle, mem_execute one cycle later with mem_address1=1; the memory model drops and then raises mem_ready -> done_a with rdata1 = model data.
REQ-033 req_a and req_b high from reset, no locks -> grant order A, B, A, B over 4 operations; never both gnt high.
REQ-034 lock_b high for 3 B ops while req_a is high -> B, B, B, then A once lock_b drops.
REQ-035 Model never returns mem_ready=1, TIMEOUT_CYCLES=16 -> timeout_err=1 sixteen cycles after ISSUE; later requests are not granted until rst.
REQ-036 rst asserted during WAIT_DONE -> all outputs 0 within the same cycle; after release, req_b is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single memory_unit.
//
// Requester A (traversal) and B (execute) each present a request with a
// function code, two addresses and write data. One requester is granted,
// its fields are latched and issued to the memory_unit as a one-cycle
// execute. The arbiter then waits for the unit to drop and raise mem_ready
// again, captures the read data and pulses the owner's done.
//
// Ports
//   clk, rst                          clock, asynchronous active-low reset
//   req_*, func_*, addr1_*, addr2_*,
//   wdata_*, lock_*                   request fields per requester
//   gnt_a/b                           grant pulse; fields captured at the edge ending it
//   done_a/b                          completion pulse; rdata1/2 valid
//   rdata1, rdata2                    read data, held until the next completion
//   mem_func, mem_execute,
//   mem_address1/2, mem_write_data    memory_unit command port
//   mem_ready, mem_read_data1/2       memory_unit status and data
//   owner                             current or last grantee (0 = A, 1 = B)
//   busy                              high whenever not idle
//   timeout_err                       sticky; operation exceeded TIMEOUT_CYCLES

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif

module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_a,
  input  logic [1:0]                    func_a,
  input  logic [`MEMORY_ADDR_WIDTH-1:0] addr1_a,
  input  logic [`MEMORY_ADDR_WIDTH-1:0] addr2_a,
  input  logic [`MEMORY_DATA_WIDTH-1:0] wdata_a,
  input  logic                          lock_a,
  input  logic                          req_b,
  input  logic [1:0]                    func_b,
  input  logic [`MEMORY_ADDR_WIDTH-1:0] addr1_b,
  input  logic [`MEMORY_ADDR_WIDTH-1:0] addr2_b,
  input  logic [`MEMORY_DATA_WIDTH-1:0] wdata_b,
  input  logic                          lock_b,
  output logic                          gnt_a,
  output logic                          gnt_b,
  output logic                          done_a,
  output logic                          done_b,
  output logic [`MEMORY_DATA_WIDTH-1:0] rdata1,
  output logic [`MEMORY_DATA_WIDTH-1:0] rdata2,
  output logic [1:0]                    mem_func,
  output logic                          mem_execute,
  output logic [`MEMORY_ADDR_WIDTH-1:0] mem_address1,
  output logic [`MEMORY_ADDR_WIDTH-1:0] mem_address2,
  output logic [`MEMORY_DATA_WIDTH-1:0] mem_write_data,
  input  logic                          mem_ready,
  input  logic [`MEMORY_DATA_WIDTH-1:0] mem_read_data1,
  input  logic [`MEMORY_DATA_WIDTH-1:0] mem_read_data2,
  output logic                          owner,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned AW = `MEMORY_ADDR_WIDTH;
  localparam int unsigned DW = `MEMORY_DATA_WIDTH;
  localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ERR} state_t;

  state_t        state, state_nxt;
  logic          run;       // set at the first edge after reset release
  logic          ptr;       // round-robin favourite when both request (0 = A)
  logic          locked;    // owner kept the memory at its last done
  logic          pick_b;
  logic          grant;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_inc;
  logic          tmr_hit;
  logic [1:0]    func_q;
  logic [AW-1:0] addr1_q, addr2_q;
  logic [DW-1:0] wdata_q;

  assign tmr_inc = tmr + TW'(1);
  assign tmr_hit = (tmr_inc == TW'(TIMEOUT_CYCLES));

  // Grant is combinational so the request fields of this cycle are the
  // ones latched at its closing edge. It is suppressed in the done cycle
  // so every completion is followed by at least one idle cycle.
  always_comb begin
    pick_b = 1'b0;
    grant  = 1'b0;
    if (locked) begin
      pick_b = owner;
      grant  = owner ? req_b : req_a;
    end else if (req_a && req_b) begin
      pick_b = ptr;
      grant  = 1'b1;
    end else begin
      pick_b = req_b;
      grant  = req_a | req_b;
    end
    if (!(run && state == IDLE && mem_ready && !done_a && !done_b))
      grant = 1'b0;
  end

  assign gnt_a = grant & ~pick_b;
  assign gnt_b = grant & pick_b;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tmr_hit) state_nxt = ERR;
                 else if (!mem_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (mem_ready) state_nxt = IDLE;
                 else if (tmr_hit) state_nxt = ERR;
      ERR:       state_nxt = ERR;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      run         <= 1'b0;
      ptr         <= 1'b0;
      locked      <= 1'b0;
      owner       <= 1'b0;
      tmr         <= '0;
      timeout_err <= 1'b0;
      done_a      <= 1'b0;
      done_b      <= 1'b0;
      rdata1      <= '0;
      rdata2      <= '0;
      func_q      <= '0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state  <= state_nxt;
      run    <= 1'b1;
      done_a <= 1'b0;
      done_b <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner   <= pick_b;
            func_q  <= pick_b ? func_b  : func_a;
            addr1_q <= pick_b ? addr1_b : addr1_a;
            addr2_q <= pick_b ? addr2_b : addr2_a;
            wdata_q <= pick_b ? wdata_b : wdata_a;
          end
        end
        ISSUE: tmr <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          tmr <= tmr_inc;
          // Completion takes priority over a timeout on the same edge.
          if (state == WAIT_DONE && mem_ready) begin
            rdata1 <= mem_read_data1;
            rdata2 <= mem_read_data2;
            done_a <= ~owner;
            done_b <= owner;
            ptr    <= ~owner;
            locked <= owner ? lock_b : lock_a;
          end else if (tmr_hit) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_execute    = (state == ISSUE);
  assign busy           = (state != IDLE);
  assign mem_func       = func_q;
  assign mem_address1   = addr1_q;
  assign mem_address2   = addr2_q;
  assign mem_write_data = wdata_q;

endmodule
